// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the datapath and the hazard sequencer.
// master = datapath side, slave = pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic        ID_use_rs1;
    logic        ID_use_rs2;
    logic [4:0]  EX_rd;
    logic        EX_MemRead;
    logic        EX_redirect;
    logic        MEM_mem_req;
    logic        dm_ack;
    logic        pc_en;
    logic        IF_ID_en;
    logic        ID_EX_en;
    logic        EX_MEM_en;
    logic        MEM_WB_en;
    logic        IF_ID_clear;
    logic        ID_EX_clear;
    logic        EX_MEM_clear;
    logic        MEM_WB_clear;
    logic        dm_busy;
    logic        dm_timeout;
    logic [31:0] stall_cycles;

    modport master (
        output ID_rs1, ID_rs2,
        output ID_use_rs1, ID_use_rs2,
        output EX_rd, EX_MemRead,
        output EX_redirect,
        output MEM_mem_req, dm_ack,
        input  pc_en, IF_ID_en,
        input  ID_EX_en, EX_MEM_en,
        input  MEM_WB_en,
        input  IF_ID_clear, ID_EX_clear,
        input  EX_MEM_clear, MEM_WB_clear,
        input  dm_busy, dm_timeout,
        input  stall_cycles
    );

    modport slave (
        input  ID_rs1, ID_rs2,
        input  ID_use_rs1, ID_use_rs2,
        input  EX_rd, EX_MemRead,
        input  EX_redirect,
        input  MEM_mem_req, dm_ack,
        output pc_en, IF_ID_en,
        output ID_EX_en, EX_MEM_en,
        output MEM_WB_en,
        output IF_ID_clear, ID_EX_clear,
        output EX_MEM_clear, MEM_WB_clear,
        output dm_busy, dm_timeout,
        output stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: load-use, EX redirects, data-memory wait + watchdog.
// Define STALL_CNT_EN to build the stall_cycles performance counter.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);

    state_e           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    logic mem_stall;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;

    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_clr;
    logic id_ex_clr;
    logic mem_wb_clr;
    logic busy;

    assign mem_stall =
        ((st_q == ST_RUN) & hz.MEM_mem_req & ~hz.dm_ack) |
        ((st_q == ST_WAIT) & ~hz.dm_ack);

    assign rs1_hit = hz.ID_use_rs1 & (hz.ID_rs1 == hz.EX_rd);
    assign rs2_hit = hz.ID_use_rs2 & (hz.ID_rs2 == hz.EX_rd);

    assign load_use = hz.EX_MemRead &
                      (hz.EX_rd != 5'd0) &
                      (rs1_hit | rs2_hit);

    // Priority: error freeze, memory wait, redirect, load-use.
    always_comb begin
        pc_en      = 1'b1;
        if_id_en   = 1'b1;
        id_ex_en   = 1'b1;
        ex_mem_en  = 1'b1;
        mem_wb_en  = 1'b1;
        if_id_clr  = 1'b0;
        id_ex_clr  = 1'b0;
        mem_wb_clr = 1'b0;
        busy       = 1'b0;
        priority case (1'b1)
            (st_q == ST_ERR): begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
            end
            mem_stall: begin
                pc_en      = 1'b0;
                if_id_en   = 1'b0;
                id_ex_en   = 1'b0;
                ex_mem_en  = 1'b0;
                mem_wb_clr = 1'b1;
                busy       = 1'b1;
            end
            hz.EX_redirect: begin
                if_id_clr = 1'b1;
                id_ex_clr = 1'b1;
            end
            load_use: begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_clr = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        unique case (st_q)
            ST_RUN: begin
                if (mem_stall) begin
                    st_d  = ST_WAIT;
                    cnt_d = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (hz.dm_ack) begin
                    st_d  = ST_RUN;
                    cnt_d = '0;
                end else if (cnt_q == TMO) begin
                    st_d  = ST_ERR;
                    tmo_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ERR: begin
                st_d = ST_ERR;
            end
            default: begin
                st_d  = ST_RUN;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= ST_RUN;
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!pc_en && (st_q != ST_ERR))
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign hz.stall_cycles = stall_q;
`else
    assign hz.stall_cycles = 32'd0;
`endif

    assign hz.pc_en        = pc_en;
    assign hz.IF_ID_en     = if_id_en;
    assign hz.ID_EX_en     = id_ex_en;
    assign hz.EX_MEM_en    = ex_mem_en;
    assign hz.MEM_WB_en    = mem_wb_en;
    assign hz.IF_ID_clear  = if_id_clr;
    assign hz.ID_EX_clear  = id_ex_clr;
    assign hz.EX_MEM_clear = 1'b0;
    assign hz.MEM_WB_clear = mem_wb_clr;
    assign hz.dm_busy      = busy;
    assign hz.dm_timeout   = tmo_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives en/clear of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC enable. Handles three cases: load-use hazards, EX-stage branch/jump redirects, and multi-cycle data-memory accesses through a req/ack handshake with a timeout watchdog. Sits beside the datapath; all pipeline registers take their en/clear from this block only.

Parameters:
TIMEOUT_CYC, 16, max cycles in WAIT before declaring a memory timeout (legal 2..255)
CNT_W, 8, width of wait counter; must hold TIMEOUT_CYC

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ID_rs1, ID_rs2  in  5  source registers of instruction in ID
ID_use_rs1, ID_use_rs2  in  1  instruction in ID actually reads rs1/rs2
EX_rd  in  5  destination of instruction in EX
EX_MemRead  in  1  instruction in EX is a load
EX_redirect  in  1  branch taken / jal / jalr resolved in EX
MEM_mem_req  in  1  instruction in MEM accesses data memory
dm_ack  in  1  data memory completes access this cycle
pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en  out  1  stage enables
IF_ID_clear, ID_EX_clear, EX_MEM_clear, MEM_WB_clear  out  1  synchronous bubble insert
dm_busy  out  1  MEM stage is waiting on memory
dm_timeout  out  1  sticky memory watchdog error
stall_cycles  out  32  performance count (see Optional Feature)

Behaviour:
- State register: RUN, WAIT, ERR. Reset → RUN, wait counter 0, dm_timeout 0, stall_cycles 0.
- All en/clear outputs are combinational from state and current inputs. Default in RUN with no hazard: all en=1, all clear=0.
- Memory stall (highest priority):
  - mem_stall = (RUN & MEM_mem_req & !dm_ack) | (WAIT & !dm_ack).
  - When mem_stall: pc_en=IF_ID_en=ID_EX_en=EX_MEM_en=0, MEM_WB_clear=1, all other clears 0, dm_busy=1.
  - RUN→WAIT on mem_stall; counter loads 1.
  - WAIT: counter increments each cycle without ack. On dm_ack: normal decode applies this cycle, →RUN, counter 0.
  - Zero-wait access (req & ack in same RUN cycle): no stall.
- Timeout:
  - In WAIT, counter==TIMEOUT_CYC without ack → ERR, dm_timeout=1.
  - ERR: all en=0, all clears 0, dm_busy=0. Only rst leaves ERR; dm_ack is ignored.
- Load-use (when no mem_stall):
  - Condition: EX_MemRead & EX_rd!=0 & ((ID_use_rs1 & ID_rs1==EX_rd) | (ID_use_rs2 & ID_rs2==EX_rd)).
  - Response: pc_en=0, IF_ID_en=0, ID_EX_clear=1. Lasts one cycle, since the load advances.
- Redirect (when no mem_stall):
  - EX_redirect → IF_ID_clear=1, ID_EX_clear=1, pc_en=1.
  - Redirect overrides load-use in the same cycle, because the dependent ID instruction is squashed.
  - A redirect arriving during mem_stall is held by the frozen EX stage and applied in the release cycle.
- EX_MEM_clear is never asserted (reserved; tied 0).
- rst asserted mid-WAIT → RUN immediately (asynchronous); counter cleared.

Optional Feature:
STALL_CNT_EN: when defined, stall_cycles is a 32-bit register that increments every cycle pc_en==0 while state!=ERR. It wraps at 2^32 and is cleared by rst. When undefined, stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- EX_MemRead=1, EX_rd=5, ID_use_rs1=1, ID_rs1=5 for one cycle → pc_en=0, IF_ID_en=0, ID_EX_clear=1 for exactly that cycle; same stimulus with EX_rd=0 → no stall.
- EX_redirect=1 together with a load-use match → IF_ID_clear=1, ID_EX_clear=1, pc_en=1.
- MEM_mem_req=1, dm_ack on 4th cycle → three cycles of pc_en=IF_ID_en=ID_EX_en=EX_MEM_en=0 with MEM_WB_clear=1, dm_busy=1; 4th cycle all en=1, state RUN.
- TIMEOUT_CYC=4, MEM_mem_req=1, dm_ack never → dm_timeout=1 after 4 WAIT cycles; later dm_ack=1 leaves all en=0; rst clears.
- EX_redirect=1 held during a 2-cycle memory wait → no clears while stalled; IF_ID_clear=ID_EX_clear=1 on ack cycle.
- rst pulse mid-WAIT → dm_busy=0 and all en=1 immediately; with STALL_CNT_EN, stall_cycles=0.
